// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - 8N1 MIDI serial receiver with centre sampling and framing-error detection
module midi_uart_rx #(
  parameter int CLOCKS_PER_BIT = 1600,
  parameter int SYNC_STAGES    = 2,
  localparam int BYTE_WIDTH    = 8
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset_l,
  input  logic                  midi_in,
  output logic [BYTE_WIDTH-1:0] data_out,
  output logic                  data_out_ready,
  output logic                  framing_error
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx;
  logic                   prev;
  logic                   fall;
  logic [2:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic [BYTE_WIDTH-1:0]  shift_q;

  assign rx   = sync_q[SYNC_STAGES-1];
  assign fall = !rx && prev;

  // Synchronizer resets to the idle-high line level so reset never fakes a start edge.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      sync_q <= '1;
      prev   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], midi_in};
      prev   <= rx;
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift_q        <= '0;
      data_out       <= '0;
      data_out_ready <= 1'b0;
      framing_error  <= 1'b0;
    end else begin
      data_out_ready <= 1'b0;
      framing_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx) begin
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift_q <= {rx, shift_q[BYTE_WIDTH-1:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving mid stop bit lets a back-to-back start edge be caught with no gap.
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx) begin
              data_out       <= shift_q;
              data_out_ready <= 1'b1;
              state          <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb/tb_midi_uart_rx.sv - scoreboard and vector-table bench for midi_uart_rx at 16 clocks per bit
module tb_midi_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       midi_in;
  logic [7:0] data_out;
  logic       data_out_ready;
  logic       framing_error;

  midi_uart_rx #(.CLOCKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clock_50_000_000(clk),
    .reset_l(reset_l),
    .midi_in(midi_in),
    .data_out(data_out),
    .data_out_ready(data_out_ready),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         tests = 0;
  int         fails = 0;
  int         rdy_count = 0;
  int         fe_count = 0;
  int         fall_cyc;
  int         pulse_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       prev_rdy = 1'b0;

  task automatic checkv(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest byte still owed.
  always @(negedge clk) begin
    if (reset_l) begin
      if (prev_rdy) checkv("ready_width", int'(data_out_ready), 0);
      if (data_out_ready && framing_error) checkv("pulse_exclusive", 1, 0);
      if (data_out_ready) begin
        rdy_count++;
        pulse_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checkv("unexpected_byte", int'(data_out), -1);
        end else begin
          exp_b = exp_q.pop_front();
          checkv("scoreboard_byte", int'(data_out), int'(exp_b));
        end
      end
      if (framing_error) fe_count++;
    end
    prev_rdy = data_out_ready;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level so a bad stop can be extended into a break.
  task automatic send_frame(input logic [7:0] b, input int bit_time, input logic stop_bit);
    midi_in  = 1'b0;
    fall_cyc = cyc + 1;
    #(bit_time);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      #(bit_time);
    end
    midi_in = stop_bit;
    #(bit_time);
  endtask

  task automatic do_reset();
    midi_in = 1'b1;
    reset_l = 1'b0;
    wait_cycles(3);
    reset_l = 1'b1;
    wait_cycles(4);
  endtask

  typedef struct {
    logic [7:0] data;
    int         bit_time;
    int         gap;
  } vec_t;

  vec_t vecs[5];
  int   r0, f0, base;

  initial begin
    // Odd bit times (154/166 ~ -/+3.75%) never land on a clock edge.
    vecs[0] = '{8'h90, 160, 0};
    vecs[1] = '{8'h3C, 160, 0};
    vecs[2] = '{8'h64, 160, 40};
    vecs[3] = '{8'h5A, 154, 40};
    vecs[4] = '{8'h5A, 166, 40};

    midi_in = 1'b1;
    reset_l = 1'b0;
    wait_cycles(3);
    checkv("reset_data_out", int'(data_out), 0);
    checkv("reset_ready", int'(data_out_ready), 0);
    checkv("reset_fe", int'(framing_error), 0);
    reset_l = 1'b1;
    wait_cycles(10);

    // Single byte with exact latency from the start edge.
    r0 = rdy_count; f0 = fe_count;
    exp_q.push_back(8'h90);
    send_frame(8'h90, 160, 1'b1);
    wait_cycles(40);
    checkv("t1_ready_count", rdy_count - r0, 1);
    if (pulse_cyc.size() > 0) checkv("t1_latency", pulse_cyc[pulse_cyc.size()-1] - fall_cyc, CPB/2 + 9*CPB + 2);
    checkv("t1_data", int'(data_out), 8'h90);
    checkv("t1_fe", fe_count - f0, 0);

    // Back-to-back bytes then baud-mismatched bytes from the table.
    r0 = rdy_count; f0 = fe_count; base = pulse_cyc.size();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].bit_time, 1'b1);
      if (vecs[i].gap > 0) wait_cycles(vecs[i].gap);
    end
    wait_cycles(40);
    checkv("t2_ready_count", rdy_count - r0, 5);
    checkv("t2_fe", fe_count - f0, 0);
    if (pulse_cyc.size() >= base + 3) begin
      checkv("t2_spacing_a", pulse_cyc[base+1] - pulse_cyc[base], 10*CPB);
      checkv("t2_spacing_b", pulse_cyc[base+2] - pulse_cyc[base+1], 10*CPB);
    end

    // Glitch shorter than half a bit.
    r0 = rdy_count; f0 = fe_count;
    midi_in = 1'b0;
    wait_cycles(5);
    midi_in = 1'b1;
    wait_cycles(40);
    checkv("t3_glitch_ready", rdy_count - r0, 0);
    checkv("t3_glitch_fe", fe_count - f0, 0);
    exp_q.push_back(8'h45);
    send_frame(8'h45, 160, 1'b1);
    wait_cycles(40);
    checkv("t3_after_data", int'(data_out), 8'h45);

    // Bad stop bit followed by a held-low break.
    do_reset();
    r0 = rdy_count; f0 = fe_count;
    send_frame(8'hAA, 160, 1'b0);
    wait_cycles(500);
    midi_in = 1'b1;
    wait_cycles(40);
    checkv("t4_fe_count", fe_count - f0, 1);
    checkv("t4_ready", rdy_count - r0, 0);
    checkv("t4_data_kept", int'(data_out), 0);
    exp_q.push_back(8'h80);
    send_frame(8'h80, 160, 1'b1);
    wait_cycles(40);
    checkv("t4_after_data", int'(data_out), 8'h80);
    checkv("t4_after_ready", rdy_count - r0, 1);

    // Reset asserted during data bit 4 of an 0xFF frame.
    r0 = rdy_count; f0 = fe_count;
    midi_in = 1'b0;
    wait_cycles(CPB);
    midi_in = 1'b1;
    wait_cycles(CPB*4 + CPB/2);
    reset_l = 1'b0;
    wait_cycles(3);
    reset_l = 1'b1;
    wait_cycles(200);
    checkv("t5_ready", rdy_count - r0, 0);
    checkv("t5_fe", fe_count - f0, 0);
    checkv("t5_data", int'(data_out), 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 160, 1'b1);
    wait_cycles(40);
    checkv("t5_after_data", int'(data_out), 8'h12);

    checkv("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
